requant_scale_sequencer: RTL and testbench

// Sequences the requantization scale ROM (1-cycle registered read) for the conv pipeline. On layer start,

---
 rtl/requant_scale_sequencer_pkg.sv | 10 +
 rtl/requant_scale_sequencer.sv | 119 +++++++++++
 tb/tb_requant_scale_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/requant_scale_sequencer_pkg.sv
// requant_scale_sequencer_pkg: shared scale type, FSM states and ROM word widths
package requant_scale_sequencer_pkg;
  localparam int MULT_W = 32;
  localparam int SHIFT_W = 6;
  typedef struct packed {
    logic [MULT_W-1:0]  mult;
    logic [SHIFT_W-1:0] shift;
  } scale_t;
  typedef enum logic [2:0] {IDLE, LAYER_RD, LAYER_CAP, READY, GRP_RD, GRP_CAP, GRP_RESP} state_t;
endpackage

// File: rtl/requant_scale_sequencer.sv
// requant_scale_sequencer: fetches layer output scale and per-group lane scales from the requant ROM
module requant_scale_sequencer
  import requant_scale_sequencer_pkg::*;
#(
  parameter int NUM_LAYERS   = 28,
  parameter int MAX_CHANNELS = 128,
  parameter int NUM_LANES    = 4,
  localparam int MULT_WIDTH  = MULT_W,
  localparam int SHIFT_WIDTH = SHIFT_W,
  localparam int LW = $clog2(NUM_LAYERS + 1),
  localparam int CW = $clog2(MAX_CHANNELS + 1),
  localparam int GW = $clog2((MAX_CHANNELS + NUM_LANES - 1) / NUM_LANES),
  localparam int NW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   layer_start,
  input  logic [LW-1:0]                          layer_idx,
  input  logic [CW-1:0]                          num_channels,
  input  logic                                   layer_done,
  output logic                                   cfg_ready,
  output logic                                   cfg_err,
  output logic [MULT_WIDTH-1:0]                  out_mult,
  output logic [SHIFT_WIDTH-1:0]                 out_shift,
  input  logic                                   grp_req_valid,
  output logic                                   grp_req_ready,
  input  logic [GW-1:0]                          grp_idx,
  output logic                                   grp_valid,
  input  logic                                   grp_ready,
  output logic [NUM_LANES-1:0]                   grp_lane_mask,
  output logic [NUM_LANES-1:0][MULT_WIDTH-1:0]   grp_mult,
  output logic [NUM_LANES-1:0][SHIFT_WIDTH-1:0]  grp_shift,
  output logic                                   rom_valid,
  output logic [LW-1:0]                          rom_layer_idx,
  output logic [CW-1:0]                          rom_weight_idx,
  input  logic [MULT_WIDTH-1:0]                  rom_mult,
  input  logic [SHIFT_WIDTH-1:0]                 rom_shift
);
  state_t state, nxt;
  scale_t out_q;
  scale_t [NUM_LANES-1:0] bank;
  logic [NUM_LANES-1:0] mask;
  logic [LW-1:0] layer_q;
  logic [CW-1:0] nch_q, widx_q;
  logic [CW:0] base_q, ch;
  logic [NW-1:0] lane_q, cap_lane;
  logic cap_v, err_q, legal, start_ok, grp_acc, last_lane;
  assign legal = !layer_idx[LW-1] && (LW+1)'(layer_idx) < (LW+1)'(NUM_LAYERS) &&
                 num_channels != '0 && (CW+1)'(num_channels) <= (CW+1)'(MAX_CHANNELS);
  assign start_ok = layer_start && (state == IDLE || state == READY);
  assign grp_req_ready = state == READY && !layer_start && !layer_done;
  assign grp_acc = grp_req_valid && grp_req_ready;
  assign ch = base_q + (CW+1)'(lane_q);
  assign last_lane = lane_q == NW'(NUM_LANES - 1);
  assign rom_valid = state == LAYER_RD || (state == GRP_RD && ch < (CW+1)'(nch_q));
  assign rom_layer_idx = layer_q;
  assign rom_weight_idx = rom_valid ? (state == LAYER_RD ? nch_q : ch[CW-1:0]) : widx_q;
  assign cfg_ready = state inside {READY, GRP_RD, GRP_CAP, GRP_RESP};
  assign cfg_err = err_q;
  assign out_mult = out_q.mult;
  assign out_shift = out_q.shift;
  assign grp_valid = state == GRP_RESP;
  assign grp_lane_mask = mask;
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign grp_mult[k] = bank[k].mult;
    assign grp_shift[k] = bank[k].shift;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE, READY: nxt = start_ok ? (legal ? LAYER_RD : IDLE) :
                         (layer_done && state == READY) ? IDLE :
                         grp_acc ? GRP_RD : state;
      LAYER_RD:    nxt = LAYER_CAP;
      LAYER_CAP:   nxt = READY;
      GRP_RD:      nxt = last_lane ? GRP_CAP : GRP_RD;
      GRP_CAP:     nxt = GRP_RESP;
      GRP_RESP:    nxt = grp_ready ? READY : GRP_RESP;
      default:     nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      out_q <= '0;
      bank <= '0;
      mask <= '0;
      layer_q <= '0;
      nch_q <= '0;
      widx_q <= '0;
      base_q <= '0;
      lane_q <= '0;
      cap_lane <= '0;
      cap_v <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      err_q <= start_ok && !legal;
      widx_q <= rom_weight_idx;
      cap_v <= rom_valid && state == GRP_RD;
      cap_lane <= lane_q;
      lane_q <= state == GRP_RD ? lane_q + 1'b1 : '0;
      if (start_ok && legal) begin
        layer_q <= layer_idx;
        nch_q <= num_channels;
      end
      if (state == LAYER_CAP) out_q <= scale_t'{rom_mult, rom_shift};
      if (grp_acc) begin
        base_q <= (CW+1)'((CW+1)'(grp_idx) * (CW+1)'(NUM_LANES));
        bank <= '0;
        mask <= '0;
      end
      if (cap_v) begin
        bank[cap_lane] <= scale_t'{rom_mult, rom_shift};
        mask[cap_lane] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_requant_scale_sequencer.sv
// tb_requant_scale_sequencer: randomized self-checking bench against a ROM-content reference model
module tb_requant_scale_sequencer;
  logic clk = 1'b0, reset_n = 1'b0;
  logic layer_start = 1'b0, layer_done = 1'b0, grp_req_valid = 1'b0, grp_ready = 1'b0;
  logic [4:0] layer_idx = '0, grp_idx = '0;
  logic [7:0] num_channels = '0;
  logic cfg_ready, cfg_err, grp_req_ready, grp_valid, rom_valid;
  logic [31:0] out_mult, rom_mult;
  logic [5:0] out_shift, rom_shift;
  logic [3:0] grp_lane_mask;
  logic [3:0][31:0] grp_mult;
  logic [3:0][5:0] grp_shift;
  logic [4:0] rom_layer_idx;
  logic [7:0] rom_weight_idx;
  int checks = 0, errors = 0;
  int cur_layer = 0, cur_nch = 0;

  always #5 clk = ~clk;

  requant_scale_sequencer dut (
    .clk(clk), .reset_n(reset_n), .layer_start(layer_start), .layer_idx(layer_idx),
    .num_channels(num_channels), .layer_done(layer_done), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .out_mult(out_mult), .out_shift(out_shift), .grp_req_valid(grp_req_valid),
    .grp_req_ready(grp_req_ready), .grp_idx(grp_idx), .grp_valid(grp_valid), .grp_ready(grp_ready),
    .grp_lane_mask(grp_lane_mask), .grp_mult(grp_mult), .grp_shift(grp_shift),
    .rom_valid(rom_valid), .rom_layer_idx(rom_layer_idx), .rom_weight_idx(rom_weight_idx),
    .rom_mult(rom_mult), .rom_shift(rom_shift)
  );

  function automatic logic [37:0] rom_word(int l, int w);
    logic [31:0] m;
    m = (32'(l) * 32'h9E3779B1) ^ (32'(w) * 32'h85EBCA6B) ^ 32'h1234_5678;
    return {m, 6'(l * 5 + w * 3 + 1)};
  endfunction

  // registered-read ROM; returns junk on cycles with no request so mistimed captures show up
  always @(posedge clk)
    {rom_mult, rom_shift} <= rom_valid ? rom_word(int'(rom_layer_idx), int'(rom_weight_idx))
                                       : {$urandom, 6'($urandom)};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd0);
    chk({tag, "_cfg_err"}, 64'(cfg_err), 64'd0);
    chk({tag, "_grp_valid"}, 64'(grp_valid), 64'd0);
    chk({tag, "_req_ready"}, 64'(grp_req_ready), 64'd0);
    chk({tag, "_rom_valid"}, 64'(rom_valid), 64'd0);
    chk({tag, "_rom_idx"}, 64'({rom_layer_idx, rom_weight_idx}), 64'd0);
    chk({tag, "_out"}, 64'({out_mult, out_shift}), 64'd0);
    chk({tag, "_mask"}, 64'(grp_lane_mask), 64'd0);
    chk({tag, "_mult_lo"}, grp_mult[1:0], 64'd0);
    chk({tag, "_mult_hi"}, grp_mult[3:2], 64'd0);
    chk({tag, "_shift"}, 64'(grp_shift), 64'd0);
  endtask

  task automatic do_cfg(input int l, input int n, input bit with_done, output bit ok);
    int ls;
    ls = l & 31;
    if (ls >= 16) ls -= 32;
    ok = ls >= 0 && ls < 28 && n >= 1 && n <= 128;
    layer_start = 1'b1; layer_idx = 5'(l); num_channels = 8'(n); layer_done = with_done;
    @(negedge clk);
    layer_start = 1'b0; layer_done = 1'b0;
    chk("cfg_err", 64'(cfg_err), 64'(!ok));
    chk("cfg_ready_c1", 64'(cfg_ready), 64'd0);
    chk("layer_rd_valid", 64'(rom_valid), 64'(ok));
    if (ok) begin
      chk("layer_rd_widx", 64'(rom_weight_idx), 64'(n));
      chk("layer_rd_layer", 64'(rom_layer_idx), 64'(ls));
      @(negedge clk);
      chk("cfg_ready_c2", 64'(cfg_ready), 64'd0);
      chk("layer_cap_rv", 64'(rom_valid), 64'd0);
      @(negedge clk);
      chk("cfg_ready_c3", 64'(cfg_ready), 64'd1);
      chk("out_scale", 64'({out_mult, out_shift}), 64'(rom_word(ls, n)));
      cur_layer = ls; cur_nch = n;
    end else begin
      @(negedge clk);
      chk("cfg_err_pulse", 64'(cfg_err), 64'd0);
      chk("cfg_err_idle", 64'({cfg_ready, grp_req_ready}), 64'd0);
    end
  endtask

  task automatic do_group(input int g, input int stall, input bit poke);
    grp_req_valid = 1'b1; grp_idx = 5'(g);
    chk("grp_req_ready", 64'(grp_req_ready), 64'd1);
    @(negedge clk);
    grp_req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int ch = g * 4 + k;
      chk("grp_rd_valid", 64'(rom_valid), 64'(ch < cur_nch));
      if (ch < cur_nch) chk("grp_rd_widx", 64'(rom_weight_idx), 64'(ch));
      chk("grp_rd_busy", 64'({grp_valid, grp_req_ready, cfg_err}), 64'd0);
      layer_start = poke && k == 1; layer_idx = 5'd3; num_channels = 8'd7;
      @(negedge clk);
    end
    layer_start = 1'b0;
    chk("grp_cap_quiet", 64'({grp_valid, rom_valid, cfg_err}), 64'd0);
    @(negedge clk);
    for (int s = 0; s <= stall; s++) begin
      logic [3:0] em;
      chk("grp_valid", 64'(grp_valid), 64'd1);
      chk("grp_hold", 64'({rom_valid, grp_req_ready, cfg_ready}), 64'd1);
      for (int k = 0; k < 4; k++) begin
        int ch = g * 4 + k;
        em[k] = ch < cur_nch;
        chk("grp_lane", 64'({grp_mult[k], grp_shift[k]}), ch < cur_nch ? 64'(rom_word(cur_layer, ch)) : 64'd0);
      end
      chk("grp_mask", 64'(grp_lane_mask), 64'(em));
      grp_ready = s == stall;
      @(negedge clk);
    end
    grp_ready = 1'b0;
    chk("grp_release", 64'({grp_valid, grp_req_ready}), 64'd1);
  endtask

  task automatic do_done();
    layer_done = 1'b1;
    #1 chk("done_blocks_req", 64'(grp_req_ready), 64'd0);
    @(negedge clk);
    layer_done = 1'b0;
    chk("done_idle", 64'({cfg_ready, grp_req_ready}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int l, n;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    do_cfg(2, 16, 1'b0, ok);
    do_group(3, 0, 1'b0);
    do_cfg(5, 10, 1'b0, ok);
    do_group(2, 5, 1'b0);
    do_group(5, 1, 1'b0);
    do_group(0, 2, 1'b1);
    do_cfg(30, 16, 1'b0, ok);
    do_cfg(4, 0, 1'b0, ok);
    do_cfg(1, 129, 1'b0, ok);
    do_cfg(7, 128, 1'b0, ok);
    do_group(31, 0, 1'b0);
    do_done();
    do_cfg(3, 9, 1'b0, ok);
    do_cfg(6, 20, 1'b1, ok);
    do_group(4, 0, 1'b0);
    grp_req_valid = 1'b1; grp_idx = 5'd0;
    @(negedge clk);
    grp_req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1 chk_zero("mid_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_cfg(1, 5, 1'b0, ok);
    do_group(1, 0, 1'b0);
    for (int it = 0; it < 30; it++) begin
      l = $urandom_range(0, 7) == 0 ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 15));
      n = $urandom_range(0, 7) == 0 ? ($urandom_range(0, 1) ? 0 : int'($urandom_range(129, 255)))
                                    : int'($urandom_range(1, 128));
      do_cfg(l, n, $urandom_range(0, 3) == 0, ok);
      if (ok) begin
        repeat ($urandom_range(1, 5))
          do_group(n <= 8 || $urandom_range(0, 1) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, (n - 1) / 4)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 2) == 0) do_done();
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
